// File: rtl/punt_pkg.sv
// Shared types and defaults for the punted-cycle SPI data bridge.
package punt_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int FRAME_BITS_DEF = 8;
  localparam int SPI_SYNC_DEF   = 2;
endpackage

// File: rtl/punt_spi_databridge_if.sv
// CPU bus byte lane plus STM32 SPI pins for the data bridge.
interface punt_spi_databridge_if #(parameter int DW = punt_pkg::FRAME_BITS_DEF);
  logic          AS20, RW, CYCLE_ACTIVE;
  logic [DW-1:0] D_IN, D_OUT;
  logic          D_OE, DATA_VALID;
  logic          SPI_CK, SPI_MOSI, SPI_MISO;

  modport master (output AS20, RW, CYCLE_ACTIVE, D_IN, SPI_CK, SPI_MOSI,
                  input  D_OUT, D_OE, DATA_VALID, SPI_MISO);
  modport slave  (input  AS20, RW, CYCLE_ACTIVE, D_IN, SPI_CK, SPI_MOSI,
                  output D_OUT, D_OE, DATA_VALID, SPI_MISO);
endinterface

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous STM32 SCK/MOSI into the CPU clock domain and
// produces single-cycle SCK edge pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = punt_pkg::SPI_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_mosi_s,
  output logic o_sck_rise,
  output logic o_sck_fall
);
  logic [SYNC_STAGES-1:0] r_ck_sync, r_mosi_sync;
  logic                   r_ck_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ck_sync   <= '0;
      r_mosi_sync <= '0;
      r_ck_prev   <= 1'b0;
    end else begin
      r_ck_sync   <= {r_ck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ck_prev   <= r_ck_sync[SYNC_STAGES-1];
    end
  end

  assign o_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign o_sck_rise =  r_ck_sync[SYNC_STAGES-1] & ~r_ck_prev;
  assign o_sck_fall = ~r_ck_sync[SYNC_STAGES-1] &  r_ck_prev;
endmodule

// File: rtl/punt_spi_databridge.sv
// CPU-side SPI responder: moves one byte per punted 68020 cycle between
// D[31:24] and the STM32 (read: STM32 -> bus, write: bus -> STM32).
module punt_spi_databridge
  import punt_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_DEF,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic                    CLKCPU_A,
  input  logic                    RST,
  punt_spi_databridge_if.slave    bus
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  state_t                r_state, w_state_nxt;
  logic                  r_rw_q, r_data_valid;
  logic [FRAME_BITS-1:0] r_tx_sr, r_rx_sr, r_rd_q;
  logic [CW-1:0]         r_bit_cnt;
  logic                  w_mosi_s, w_sck_rise, w_sck_fall, w_last_bit;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (CLKCPU_A),
    .rst       (RST),
    .i_sck     (bus.SPI_CK),
    .i_mosi    (bus.SPI_MOSI),
    .o_mosi_s  (w_mosi_s),
    .o_sck_rise(w_sck_rise),
    .o_sck_fall(w_sck_fall)
  );

  assign w_last_bit = (r_bit_cnt == CW'(FRAME_BITS - 1));

  always_ff @(posedge CLKCPU_A or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A released strobe aborts from any state, even on the final SCK edge.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.AS20) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (bus.CYCLE_ACTIVE) w_state_nxt = LOAD;
        LOAD:    w_state_nxt = SHIFT;
        SHIFT:   if (w_sck_rise && w_last_bit) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLKCPU_A or posedge RST) begin
    if (RST) begin
      r_rw_q       <= 1'b0;
      r_data_valid <= 1'b0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_rd_q       <= '0;
      r_bit_cnt    <= '0;
    end else if (bus.AS20) begin
      r_data_valid <= 1'b0;
      r_bit_cnt    <= '0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_rw_q    <= bus.RW;
          r_tx_sr   <= bus.RW ? '0 : bus.D_IN;
          r_rx_sr   <= '0;
          r_bit_cnt <= '0;
        end
        SHIFT: begin
          if (w_sck_rise) begin
            r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], w_mosi_s};
            if (r_bit_cnt != CW'(FRAME_BITS)) r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_last_bit) begin
              r_rd_q       <= {r_rx_sr[FRAME_BITS-2:0], w_mosi_s};
              r_data_valid <= 1'b1;
            end
          end
          // MSB is already on MISO before the first rise; shift only after it.
          if (w_sck_fall && r_bit_cnt != '0)
            r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign bus.SPI_MISO   = r_tx_sr[FRAME_BITS-1];
  assign bus.D_OUT      = r_rd_q;
  assign bus.DATA_VALID = r_data_valid;
  assign bus.D_OE       = (r_state == DONE) & r_rw_q & ~bus.AS20;
endmodule

// File: tb/tb_punt_spi_databridge.sv
// Directed + randomized bench for punt_spi_databridge with an STM32-style SPI master.
module tb_punt_spi_databridge;
  import punt_pkg::*;

  logic CLKCPU_A, RST;
  int   n_tests, n_fail;
  logic oe_seen;

  punt_spi_databridge_if bus ();

  punt_spi_databridge dut (.CLKCPU_A(CLKCPU_A), .RST(RST), .bus(bus));

  initial CLKCPU_A = 1'b0;
  always #5 CLKCPU_A = ~CLKCPU_A;

  always @(negedge CLKCPU_A) if (bus.D_OE === 1'b1) oe_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLKCPU_A);
    #1;
  endtask

  task automatic cycle_start(input logic rw, input logic [7:0] din);
    bus.RW = rw; bus.D_IN = din; bus.CYCLE_ACTIVE = 1'b1; bus.AS20 = 1'b0;
    tick(4);
  endtask

  task automatic cycle_end();
    bus.AS20 = 1'b1;
    tick(2);
    bus.CYCLE_ACTIVE = 1'b0;
  endtask

  // Mode 0 master: 4-cycle low then 4-cycle high per bit, MISO sampled just before the rise.
  task automatic spi_xfer(input logic [15:0] mo, input int n, output logic [15:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      bus.SPI_MOSI = mo[15-i];
      tick(4);
      mi = {mi[14:0], bus.SPI_MISO};
      bus.SPI_CK = 1'b1;
      tick(4);
      bus.SPI_CK = 1'b0;
    end
    tick(4);
  endtask

  initial begin
    logic [15:0] mi;
    logic [7:0]  b;
    n_tests = 0; n_fail = 0; oe_seen = 1'b0;
    bus.AS20 = 1'b1; bus.RW = 1'b1; bus.CYCLE_ACTIVE = 1'b0; bus.D_IN = '0;
    bus.SPI_CK = 1'b0; bus.SPI_MOSI = 1'b0;
    RST = 1'b1;
    tick(3);
    chk("rst_dout", 32'(bus.D_OUT), 0);
    chk("rst_doe", 32'(bus.D_OE), 0);
    chk("rst_miso", 32'(bus.SPI_MISO), 0);
    chk("rst_dv", 32'(bus.DATA_VALID), 0);
    RST = 1'b0;
    tick(2);

    // Punted read of 0xA5
    cycle_start(1'b1, 8'h00);
    spi_xfer({8'hA5, 8'h00}, 8, mi);
    chk("rd_miso_zero", 32'(mi[7:0]), 0);
    chk("rd_dv", 32'(bus.DATA_VALID), 1);
    chk("rd_doe", 32'(bus.D_OE), 1);
    chk("rd_dout", 32'(bus.D_OUT), 32'h A5);
    bus.AS20 = 1'b1;
    #1;
    chk("rd_doe_drop", 32'(bus.D_OE), 0);
    chk("rd_dv_hold", 32'(bus.DATA_VALID), 1);
    tick(1);
    chk("rd_dv_clear", 32'(bus.DATA_VALID), 0);
    tick(1);
    bus.CYCLE_ACTIVE = 1'b0;

    // Punted write of 0x3C
    oe_seen = 1'b0;
    cycle_start(1'b0, 8'h3C);
    spi_xfer(16'h0000, 8, mi);
    chk("wr_miso_bits", 32'(mi[7:0]), 32'h3C);
    chk("wr_dv", 32'(bus.DATA_VALID), 1);
    chk("wr_doe_never", 32'(oe_seen), 0);
    cycle_end();

    // Abort after 4 bits, then a clean read of 0x81
    cycle_start(1'b1, 8'h00);
    spi_xfer({8'hFF, 8'h00}, 4, mi);
    chk("abort_dv_mid", 32'(bus.DATA_VALID), 0);
    cycle_end();
    chk("abort_dv", 32'(bus.DATA_VALID), 0);
    chk("abort_idle", 32'(dut.r_state), 32'(IDLE));
    cycle_start(1'b1, 8'h00);
    spi_xfer({8'h81, 8'h00}, 8, mi);
    chk("abort_next_dout", 32'(bus.D_OUT), 32'h81);
    chk("abort_next_dv", 32'(bus.DATA_VALID), 1);
    cycle_end();

    // Idle noise: strobe low but cycle not ours
    bus.AS20 = 1'b0; bus.CYCLE_ACTIVE = 1'b0; bus.RW = 1'b0; bus.D_IN = 8'hFF;
    spi_xfer(16'hFFFF, 16, mi);
    spi_xfer(16'hFFFF, 4, mi);
    chk("noise_idle", 32'(dut.r_state), 32'(IDLE));
    chk("noise_dv", 32'(bus.DATA_VALID), 0);
    chk("noise_miso", 32'(bus.SPI_MISO), 0);
    bus.AS20 = 1'b1;
    tick(2);

    // Overrun: 12 pulses, 0xF0 then 0xFF
    cycle_start(1'b1, 8'h00);
    spi_xfer({8'hF0, 8'hFF}, 12, mi);
    chk("ovr_dout", 32'(bus.D_OUT), 32'hF0);
    chk("ovr_dv", 32'(bus.DATA_VALID), 1);
    chk("ovr_doe", 32'(bus.D_OE), 1);
    cycle_end();

    // Randomized reads and writes against the byte-level model
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      cycle_start(1'b1, 8'($urandom));
      spi_xfer({b, 8'h00}, 8, mi);
      chk("rnd_rd_dout", 32'(bus.D_OUT), 32'(b));
      chk("rnd_rd_doe", 32'(bus.D_OE), 1);
      cycle_end();
      b = 8'($urandom);
      oe_seen = 1'b0;
      cycle_start(1'b0, b);
      spi_xfer(16'($urandom), 8, mi);
      chk("rnd_wr_miso", 32'(mi[7:0]), 32'(b));
      chk("rnd_wr_dv", 32'(bus.DATA_VALID), 1);
      chk("rnd_wr_noe", 32'(oe_seen), 0);
      cycle_end();
    end

    // Reset mid-SHIFT of a write of 0xFF
    cycle_start(1'b0, 8'hFF);
    chk("prerst_miso", 32'(bus.SPI_MISO), 1);
    bus.SPI_MOSI = 1'b1; bus.SPI_CK = 1'b1;
    tick(4);
    #2 RST = 1'b1;
    #1;
    chk("arst_miso", 32'(bus.SPI_MISO), 0);
    chk("arst_dout", 32'(bus.D_OUT), 0);
    chk("arst_dv", 32'(bus.DATA_VALID), 0);
    chk("arst_doe", 32'(bus.D_OE), 0);
    bus.AS20 = 1'b1; bus.SPI_CK = 1'b0; bus.CYCLE_ACTIVE = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(3);
    chk("post_rst_idle", 32'(dut.r_state), 32'(IDLE));
    chk("post_rst_miso", 32'(bus.SPI_MISO), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
